// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
//   arb_state_e : controller state (clearing the RAM, or serving requests)
//   MaxReq      : largest supported requester count
//   rr_next     : round-robin pick, returns the one-hot winner starting at ptr
package dpram_arb_pkg;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } arb_state_e;

    localparam int unsigned MaxReq = 4;

    // Scan from ptr upward (wrapping at n) and return the first requesting slot, one-hot.
    function automatic logic [MaxReq-1:0] rr_next(input logic [1:0]        ptr,
                                                  input logic [MaxReq-1:0] req,
                                                  input int unsigned       n);
        logic [MaxReq-1:0] gnt;
        logic              found;
        logic [1:0]        idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            if (k < n) begin
                idx = 2'((32'(ptr) + k) % n);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own rotating pointer.
//   clk, rst : clock and asynchronous active-high reset (pointer returns to 0)
//   req      : request vector, one bit per requester
//   en       : the current candidate grant is accepted; advance the pointer past it
//   gnt      : one-hot candidate grant (combinational), zero when nothing requests
module rr_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt
);

    logic [1:0]        ptr_q, ptr_d;
    logic [MaxReq-1:0] req_ext;
    logic [MaxReq-1:0] gnt_ext;
    logic [1:0]        win;
    logic              unused_gnt_ext;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        gnt_ext              = rr_next(ptr_q, req_ext, NUM_REQ);
        gnt                  = gnt_ext[NUM_REQ-1:0];
    end

    // Slots above NUM_REQ never request, so their grant bits are always zero.
    assign unused_gnt_ext = ^gnt_ext;

    always_comb begin
        win = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win = 2'(i);
            end
        end
        ptr_d = ptr_q;
        if (en && |gnt) begin
            ptr_d = (win == 2'(NUM_REQ - 1)) ? 2'd0 : win + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one dual-port RAM among NUM_REQ requesters. Writes go to RAM port 0, reads to port 1,
// each with its own round-robin arbiter. After reset the RAM is cleared to zero before any
// request is accepted.
//   clk, rst                              : clock, asynchronous active-high reset
//   req_valid/req_we/req_addr/req_wdata   : packed per-requester request fields
//   req_ready                             : combinational grant per requester
//   rsp_valid/rsp_data                    : one-hot read response, one cycle after the read grant
//   init_done                             : RAM clear finished
//   wr_en/port_en_0/addr_in_0/data_in     : RAM port 0 (write)
//   port_en_1/addr_in_1/data_out_1        : RAM port 1 (registered read)
// Build option DPRAM_ARB_COLLISION_FWD_EN: a same-address read/write pair is granted together and
// the write data is forwarded as the read response. Without it the read waits one cycle.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          init_done,
    output logic                          wr_en,
    output logic                          port_en_0,
    output logic [ADDR_WIDTH-1:0]         addr_in_0,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          port_en_1,
    output logic [ADDR_WIDTH-1:0]         addr_in_1,
    input  logic [DATA_WIDTH-1:0]         data_out_1
);

    localparam int unsigned CNT_W = ADDR_WIDTH;

    arb_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0]   wr_cand, rd_cand;
    logic [NUM_REQ-1:0]   wr_gnt, rd_cgnt, rd_gnt;
    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                 collision;
    logic                 rd_accept;

    // Requests are only visible to the arbiters once the clear is finished.
    always_comb begin
        wr_cand = '0;
        rd_cand = '0;
        if (state_q == StRun) begin
            wr_cand = req_valid & req_we;
            rd_cand = req_valid & ~req_we;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_cand),
        .en  (1'b1),
        .gnt (wr_gnt)
    );

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_cand),
        .en  (rd_accept),
        .gnt (rd_cgnt)
    );

    always_comb begin
        w_addr = '0;
        w_data = '0;
        r_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                w_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_data = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_cgnt[i]) begin
                r_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign collision = (|wr_gnt) && (|rd_cgnt) && (w_addr == r_addr);

`ifdef DPRAM_ARB_COLLISION_FWD_EN
    logic                  fwd_sel_q, fwd_sel_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    assign rd_accept  = 1'b1;
    assign fwd_sel_d  = collision;
    assign fwd_data_d = w_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_sel_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_sel_q  <= fwd_sel_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    always_comb begin
        rsp_data = '0;
        if (|rsp_valid_q) begin
            rsp_data = fwd_sel_q ? fwd_data_q : data_out_1;
        end
    end
`else
    // The RAM would return the old word, so the read is held back one cycle instead.
    assign rd_accept = ~collision;

    always_comb begin
        rsp_data = '0;
        if (|rsp_valid_q) begin
            rsp_data = data_out_1;
        end
    end
`endif

    assign rd_gnt    = rd_accept ? rd_cgnt : '0;
    assign rsp_valid = rsp_valid_q;
    assign init_done = (state_q == StRun);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        req_ready   = '0;
        wr_en       = 1'b0;
        port_en_0   = 1'b0;
        addr_in_0   = '0;
        data_in     = '0;
        port_en_1   = 1'b0;
        addr_in_1   = '0;
        case (state_q)
            StInit: begin
                wr_en     = 1'b1;
                port_en_0 = 1'b1;
                addr_in_0 = cnt_q;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (|wr_gnt) begin
                    wr_en     = 1'b1;
                    port_en_0 = 1'b1;
                    addr_in_0 = w_addr;
                    data_in   = w_data;
                end
                if (|rd_gnt) begin
                    port_en_1 = 1'b1;
                    addr_in_1 = r_addr;
                end
                req_ready   = wr_gnt | rd_gnt;
                rsp_valid_d = rd_gnt;
            end
            default: state_d = StInit;
        endcase
        // Outputs must read zero while reset is held, not just after the next edge.
        if (rst) begin
            req_ready = '0;
            wr_en     = 1'b0;
            port_en_0 = 1'b0;
            addr_in_0 = '0;
            data_in   = '0;
            port_en_1 = 1'b0;
            addr_in_1 = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: a RAM model on the port side, a reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_dpram_arbiter;

    localparam int N     = 2;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            init_done, wr_en, port_en_0, port_en_1;
    logic [AW-1:0]   addr_in_0, addr_in_1;
    logic [DW-1:0]   data_in;
    logic [DW-1:0]   data_out_1 = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dpram_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .init_done  (init_done),
        .wr_en      (wr_en),
        .port_en_0  (port_en_0),
        .addr_in_0  (addr_in_0),
        .data_in    (data_in),
        .port_en_1  (port_en_1),
        .addr_in_1  (addr_in_1),
        .data_out_1 (data_out_1)
    );

    // RAM: write on port 0, registered read on port 1; powers up with junk so the clear matters.
    logic [DW-1:0] ram [DEPTH] = '{default: 8'hEE};
    always @(posedge clk) begin
        if (wr_en && port_en_0) ram[addr_in_0] <= data_in;
        if (port_en_1) data_out_1 <= ram[addr_in_1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model, compared on every falling edge ----------------
    int            init_cnt = 0;
    int            wptr = 0;
    int            rptr = 0;
    int            ww, rw, idx;
    logic [DW-1:0] mm [DEPTH];
    logic [N-1:0]  pend_v = '0;
    logic [DW-1:0] pend_d = '0;
    logic [N-1:0]  exp_ready;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ready", 32'(req_ready), 0);
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_rsp_data", 32'(rsp_data), 0);
                chk("rst_init_done", 32'(init_done), 0);
                chk("rst_wr_en", 32'(wr_en), 0);
                chk("rst_port_en_1", 32'(port_en_1), 0);
                init_cnt = 0;
                wptr     = 0;
                rptr     = 0;
                pend_v   = '0;
            end else begin
                chk("m_rsp_valid", 32'(rsp_valid), 32'(pend_v));
                if (pend_v != '0) chk("m_rsp_data", 32'(rsp_data), 32'(pend_d));
                pend_v = '0;
                if (init_cnt < DEPTH) begin
                    chk("m_init_done", 32'(init_done), 0);
                    chk("m_init_ready", 32'(req_ready), 0);
                    chk("m_init_wr_en", 32'(wr_en & port_en_0), 1);
                    chk("m_init_addr", 32'(addr_in_0), init_cnt);
                    chk("m_init_data", 32'(data_in), 0);
                    mm[init_cnt] = '0;
                    init_cnt++;
                end else begin
                    chk("m_init_done", 32'(init_done), 1);
                    ww = -1;
                    rw = -1;
                    for (int k = 0; k < N; k++) begin
                        idx = (wptr + k) % N;
                        if (ww < 0 && req_valid[idx] && req_we[idx]) ww = idx;
                    end
                    for (int k = 0; k < N; k++) begin
                        idx = (rptr + k) % N;
                        if (rw < 0 && req_valid[idx] && !req_we[idx]) rw = idx;
                    end
                    exp_ready = '0;
                    wa = '0;
                    wd = '0;
                    ra = '0;
                    if (ww >= 0) begin
                        wa = req_addr[ww*AW +: AW];
                        wd = req_wdata[ww*DW +: DW];
                        exp_ready[ww] = 1'b1;
                    end
                    if (rw >= 0) begin
                        ra = req_addr[rw*AW +: AW];
                        pend_d = mm[ra];
                        if (ww >= 0 && wa == ra) begin
`ifdef DPRAM_ARB_COLLISION_FWD_EN
                            pend_d = wd;
`else
                            rw = -1;
`endif
                        end
                    end
                    if (rw >= 0) begin
                        exp_ready[rw] = 1'b1;
                        pend_v[rw]    = 1'b1;
                        rptr          = (rw + 1) % N;
                    end
                    chk("m_ready", 32'(req_ready), 32'(exp_ready));
                    chk("m_wr_en", 32'(wr_en & port_en_0), 32'(ww >= 0));
                    chk("m_port_en_1", 32'(port_en_1), 32'(rw >= 0));
                    if (ww >= 0) begin
                        chk("m_addr_in_0", 32'(addr_in_0), 32'(wa));
                        chk("m_data_in", 32'(data_in), 32'(wd));
                        mm[wa] = wd;
                        wptr   = (ww + 1) % N;
                    end
                    if (rw >= 0) chk("m_addr_in_1", 32'(addr_in_1), 32'(ra));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]         = 1'b1;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic run_clear(input string tag);
        for (int c = 0; c < DEPTH; c++) begin
            chk({tag, "_wr_en"}, 32'(wr_en), 1);
            chk({tag, "_addr"}, 32'(addr_in_0), c);
            chk({tag, "_ready"}, 32'(req_ready), 0);
            chk({tag, "_done"}, 32'(init_done), 0);
            step();
            #1;
        end
        chk({tag, "_done_after"}, 32'(init_done), 1);
    endtask

    initial begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        step();
        step();

        // 1: clear after reset release
        rst = 1'b0;
        #1;
        run_clear("t1");

        // 2: write then read back
        set_req(0, 1'b1, 4'd3, 8'hA5);
        #1 chk("t2_wr_ready", 32'(req_ready), 1);
        step();
        req_valid[0] = 1'b0;
        set_req(1, 1'b0, 4'd3, 8'h00);
        #1 chk("t2_rd_ready", 32'(req_ready), 2);
        step();
        req_valid = '0;
        #1 chk("t2_rsp_valid", 32'(rsp_valid), 2);
        chk("t2_rsp_data", 32'(rsp_data), 'hA5);

        // bring the write pointer back to requester 0
        set_req(1, 1'b1, 4'd8, 8'h77);
        #1 chk("t3_pre_ready", 32'(req_ready), 2);
        step();
        req_valid = '0;

        // 3: two held writers alternate, requester 0 first
        set_req(0, 1'b1, 4'd6, 8'h11);
        set_req(1, 1'b1, 4'd7, 8'h22);
        for (int c = 0; c < 6; c++) begin
            #1 chk("t3_alternate", 32'(req_ready), (c % 2 == 0) ? 1 : 2);
            step();
        end
        req_valid = '0;

        // 4: same-address write and read
        set_req(0, 1'b1, 4'd5, 8'h3C);
        set_req(1, 1'b0, 4'd5, 8'h00);
`ifdef DPRAM_ARB_COLLISION_FWD_EN
        #1 chk("t4_ready", 32'(req_ready), 3);
        step();
        req_valid = '0;
`else
        #1 chk("t4_ready_wr", 32'(req_ready), 1);
        step();
        req_valid[0] = 1'b0;
        #1 chk("t4_ready_rd", 32'(req_ready), 2);
        step();
        req_valid = '0;
`endif
        #1 chk("t4_rsp_valid", 32'(rsp_valid), 2);
        chk("t4_rsp_data", 32'(rsp_data), 'h3C);

        // 5: independent write and read in the same cycle
        set_req(0, 1'b1, 4'd2, 8'h5A);
        set_req(1, 1'b0, 4'd9, 8'h00);
        #1 chk("t5_ready", 32'(req_ready), 3);
        step();
        req_valid = '0;
        #1 chk("t5_rsp_valid", 32'(rsp_valid), 2);
        chk("t5_rsp_data", 32'(rsp_data), 0);

        // address boundaries, then back-to-back reads
        set_req(0, 1'b1, 4'd0, 8'h0F);
        set_req(1, 1'b1, 4'd15, 8'hF0);
        #1 chk("t7_wr_first", 32'(req_ready), 2);
        step();
        req_valid[1] = 1'b0;
        #1 chk("t7_wr_second", 32'(req_ready), 1);
        step();
        set_req(0, 1'b0, 4'd15, 8'h00);
        set_req(1, 1'b0, 4'd0, 8'h00);
        #1 chk("t7_rd_first", 32'(req_ready), 1);
        step();
        req_valid[0] = 1'b0;
        #1 chk("t7_rd_second", 32'(req_ready), 2);
        chk("t7_rsp0_valid", 32'(rsp_valid), 1);
        chk("t7_rsp0_data", 32'(rsp_data), 'hF0);
        step();
        req_valid = '0;
        #1 chk("t7_rsp1_valid", 32'(rsp_valid), 2);
        chk("t7_rsp1_data", 32'(rsp_data), 'h0F);

        // 6: reset with a read in flight, requests held throughout
        set_req(0, 1'b1, 4'd1, 8'h99);
        set_req(1, 1'b0, 4'd3, 8'h00);
        #1 chk("t6_ready_pre", 32'(req_ready), 3);
        step();
        rst = 1'b1;
        #1;
        chk("t6_ready", 32'(req_ready), 0);
        chk("t6_rsp_valid", 32'(rsp_valid), 0);
        chk("t6_rsp_data", 32'(rsp_data), 0);
        chk("t6_init_done", 32'(init_done), 0);
        chk("t6_ram_ctrl", 32'({wr_en, port_en_0, port_en_1}), 0);
        chk("t6_ram_bus", 32'({addr_in_0, data_in, addr_in_1}), 0);
        step();
        rst = 1'b0;
        #1;
        run_clear("t6");
        chk("t6_ready_post", 32'(req_ready), 3);
        step();
        req_valid = '0;
        #1 chk("t6_rsp_valid_post", 32'(rsp_valid), 2);
        chk("t6_rsp_cleared", 32'(rsp_data), 0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
